// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Multicycle instruction sequencer that sits directly upstream of the control
// unit. It owns the PC, fetches an instruction word over an ihit handshake,
// holds it for the decoder, then retires it either directly (ALU/branch/jump)
// or after a data-memory access completed over a dhit handshake. A halt
// request from the decoder parks the block in a sticky HALTED state that only
// RST leaves.
//
// Optional feature (compile-time macro FETCH_PERF_EN):
//   adds instr_count / stall_count performance counters. When the macro is
//   not defined those ports and registers do not exist.
//
// Ports:
//   CLK          system clock, all state changes on the rising edge
//   RST          synchronous active-high reset
//   ihit         instruction memory returned imemload this cycle
//   imemload     instruction word from instruction memory
//   imemREN      instruction read request (high in FETCH)
//   imemaddr     instruction address, always equal to pc
//   dhit         data memory access completed this cycle
//   dmemREN      data read request (DATA state, load)
//   dmemWEN      data write request (DATA state, store)
//   MemRead      decoder: current instruction is a load
//   MemWrite     decoder: current instruction is a store
//   PC_src       decoder next-PC select
//   zero         ALU zero flag for branches
//   halt_in      decoder/overflow halt request
//   jr_addr      rs register value for JR
//   instr        held instruction to the decoder
//   instr_valid  instr is valid and being executed
//   pc           current PC
//   pc_plus4     pc + 4, JAL link value
//   commit       one-cycle retire pulse, qualifies the register-file write
//   instr_count  (FETCH_PERF_EN) retired instruction count
//   stall_count  (FETCH_PERF_EN) cycles spent waiting on ihit/dhit
//   halt         sticky halted flag
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        dhit,
    output logic        dmemREN,
    output logic        dmemWEN,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  PC_src,
    input  logic        zero,
    input  logic        halt_in,
    input  logic [31:0] jr_addr,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        commit,
`ifdef FETCH_PERF_EN
    output logic [31:0] instr_count,
    output logic [31:0] stall_count,
`endif
    output logic        halt
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_DATA   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    // Next-PC select encodings driven by the decoder.
    localparam logic [2:0] PCS_SEQ = 3'b000;
    localparam logic [2:0] PCS_BEQ = 3'b001;
    localparam logic [2:0] PCS_J   = 3'b010;
    localparam logic [2:0] PCS_JR  = 3'b011;
    localparam logic [2:0] PCS_BNE = 3'b100;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      state_q,       state_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] instr_q,       instr_d;
    logic        halt_q,        halt_d;
    logic        rd_flag_q,     rd_flag_d;
    logic        wr_flag_q,     wr_flag_d;
    logic        imem_ren_q,    imem_ren_d;
    logic        instr_valid_q, instr_valid_d;
    logic        dmem_ren_q,    dmem_ren_d;
    logic        dmem_wen_q,    dmem_wen_d;
`ifdef FETCH_PERF_EN
    logic [31:0] instr_count_q, instr_count_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        stall_cycle;
`endif

    // ------------------------------------------------------------------
    // Next-PC computation (only used in the commit cycle)
    // ------------------------------------------------------------------
    logic [31:0] pc_plus4_w;
    logic [31:0] branch_off;
    logic [31:0] btarget;
    logic [31:0] jtarget;
    logic [31:0] jrtarget;
    logic [31:0] next_pc;
    logic        commit_raw;

    assign pc_plus4_w = pc_q + 32'd4;
    // Sign-extended word offset: imm16 << 2.
    assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign btarget    = pc_plus4_w + branch_off;
    assign jtarget    = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
    // JR forces word alignment by clearing the two low address bits.
    assign jrtarget   = jr_addr & 32'hFFFF_FFFC;

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        next_pc = pc_plus4_w;
        case (PC_src)
            PCS_SEQ: next_pc = pc_plus4_w;
            PCS_BEQ: next_pc = zero ? btarget : pc_plus4_w;
            PCS_BNE: next_pc = (!zero) ? btarget : pc_plus4_w;
            PCS_J:   next_pc = jtarget;
            PCS_JR:  next_pc = jrtarget;
            default: next_pc = pc_plus4_w;   // reserved selects behave as sequential
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        halt_d     = halt_q;
        rd_flag_d  = rd_flag_q;
        wr_flag_d  = wr_flag_q;
        commit_raw = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (ihit) begin
                    instr_d = imemload;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                if (halt_in) begin
                    halt_d  = 1'b1;
                    state_d = S_HALTED;
                end else if (MemRead || MemWrite) begin
                    // Both may be set; both requests go out and the memory
                    // side decides.
                    rd_flag_d = MemRead;
                    wr_flag_d = MemWrite;
                    state_d   = S_DATA;
                end else begin
                    commit_raw = 1'b1;
                    pc_d       = next_pc;
                    state_d    = S_FETCH;
                end
            end

            S_DATA: begin
                if (dhit) begin
                    commit_raw = 1'b1;
                    pc_d       = next_pc;
                    state_d    = S_FETCH;
                end
            end

            S_HALTED: begin
                state_d = S_HALTED;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Outputs are registered: decode them from the state being entered
        // so they are valid in the same cycle the state is.
        imem_ren_d    = (state_d == S_FETCH);
        instr_valid_d = (state_d == S_EXEC) || (state_d == S_DATA);
        dmem_ren_d    = (state_d == S_DATA) && rd_flag_d;
        dmem_wen_d    = (state_d == S_DATA) && wr_flag_d;
    end

`ifdef FETCH_PERF_EN
    always_comb begin
        stall_cycle   = ((state_q == S_FETCH) && !ihit) ||
                        ((state_q == S_DATA)  && !dhit);
        instr_count_d = instr_count_q + {31'd0, commit_raw};
        stall_count_d = stall_count_q + {31'd0, stall_cycle};
    end
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge regardless of block order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_FETCH;
            pc_q          <= PC_INIT;
            instr_q       <= 32'h0000_0000;
            halt_q        <= 1'b0;
            rd_flag_q     <= 1'b0;
            wr_flag_q     <= 1'b0;
            imem_ren_q    <= 1'b1;
            instr_valid_q <= 1'b0;
            dmem_ren_q    <= 1'b0;
            dmem_wen_q    <= 1'b0;
`ifdef FETCH_PERF_EN
            instr_count_q <= 32'd0;
            stall_count_q <= 32'd0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            halt_q        <= halt_d;
            rd_flag_q     <= rd_flag_d;
            wr_flag_q     <= wr_flag_d;
            imem_ren_q    <= imem_ren_d;
            instr_valid_q <= instr_valid_d;
            dmem_ren_q    <= dmem_ren_d;
            dmem_wen_q    <= dmem_wen_d;
`ifdef FETCH_PERF_EN
            instr_count_q <= instr_count_d;
            stall_count_q <= stall_count_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imemREN     = imem_ren_q;
    assign imemaddr    = pc_q;
    assign dmemREN     = dmem_ren_q;
    assign dmemWEN     = dmem_wen_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_w;
    // Reset in the retire cycle wins: suppress the register-file write.
    assign commit      = commit_raw && !RST;
    assign halt        = halt_q;
`ifdef FETCH_PERF_EN
    assign instr_count = instr_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer. Inputs are driven 1 ns after the rising
// edge and outputs are sampled in the same window, well clear of the next
// edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dhit;
    logic        dmemREN;
    logic        dmemWEN;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  PC_src;
    logic        zero;
    logic        halt_in;
    logic [31:0] jr_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit;
    logic        halt;
`ifdef FETCH_PERF_EN
    logic [31:0] instr_count;
    logic [31:0] stall_count;
`endif

    int errors = 0;
    int checks = 0;

    fetch_sequencer #(.PC_INIT(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .imemload    (imemload),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .dhit        (dhit),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .PC_src      (PC_src),
        .zero        (zero),
        .halt_in     (halt_in),
        .jr_addr     (jr_addr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .commit      (commit),
`ifdef FETCH_PERF_EN
        .instr_count (instr_count),
        .stall_count (stall_count),
`endif
        .halt        (halt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and land 1 ns after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit     = 1'b0;
        imemload = 32'h0;
        dhit     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        PC_src   = 3'b000;
        zero     = 1'b0;
        halt_in  = 1'b0;
        jr_addr  = 32'h0;
    endtask

    // Fetch with immediate ihit, then execute a non-memory instruction and
    // check the retire pulse and the resulting PC.
    task automatic run_simple(input string tag, input logic [31:0] word,
                              input logic [2:0] sel, input logic z,
                              input logic [31:0] jr, input logic [31:0] exp_pc);
        ihit     = 1'b1;
        imemload = word;
        tick();
        ihit     = 1'b0;
        PC_src   = sel;
        zero     = z;
        jr_addr  = jr;
        #1;
        check({tag, "_commit"}, {31'd0, commit}, 32'd1);
        tick();
        idle_inputs();
        #1;
        check({tag, "_pc"}, pc, exp_pc);
    endtask

    initial begin
        idle_inputs();
        RST = 1'b1;
        tick();
        tick();

        // ---------------- reset state ----------------
        check("rst_pc",        pc,                    32'h0);
        check("rst_instr",     instr,                 32'h0);
        check("rst_halt",      {31'd0, halt},         32'd0);
        check("rst_imemREN",   {31'd0, imemREN},      32'd1);
        check("rst_valid",     {31'd0, instr_valid},  32'd0);
        check("rst_dREN",      {31'd0, dmemREN},      32'd0);
        check("rst_dWEN",      {31'd0, dmemWEN},      32'd0);
        check("rst_commit",    {31'd0, commit},       32'd0);
        RST = 1'b0;

        // ---------------- ADDU, ihit on first cycle ----------------
        ihit     = 1'b1;
        imemload = 32'h0022_1821;
        #1;
        check("addu_imemaddr", imemaddr,              32'h0);
        check("addu_c1_commit",{31'd0, commit},       32'd0);
        tick();
        ihit = 1'b0;
        imemload = 32'h0;
        #1;
        check("addu_valid",    {31'd0, instr_valid},  32'd1);
        check("addu_instr",    instr,                 32'h0022_1821);
        check("addu_imemREN",  {31'd0, imemREN},      32'd0);
        check("addu_commit",   {31'd0, commit},       32'd1);
        check("addu_link",     pc_plus4,              32'h4);
        tick();
        check("addu_pc",       pc,                    32'h4);
        check("addu_c3_commit",{31'd0, commit},       32'd0);
        check("addu_c3_valid", {31'd0, instr_valid},  32'd0);

        // ---------------- delayed ihit ----------------
        imemload = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wait_imemREN", {31'd0, imemREN},   32'd1);
            check("wait_pc",      pc,                 32'h4);
            tick();
        end
        ihit     = 1'b1;
        imemload = 32'h0085_3021;
        #1;
        check("wait_imemREN4", {31'd0, imemREN},      32'd1);
        check("wait_instr_old",instr,                 32'h0022_1821);
        tick();
        ihit = 1'b0;
        imemload = 32'hDEAD_BEEF;
        #1;
        check("wait_instr",    instr,                 32'h0085_3021);
        tick();
        idle_inputs();
        #1;
        check("wait_pc_after", pc,                    32'h8);

        // ---------------- load with dhit after 2 cycles ----------------
        ihit     = 1'b1;
        imemload = 32'h8C43_0004;
        tick();
        ihit    = 1'b0;
        MemRead = 1'b1;
        #1;
        check("lw_exec_commit",{31'd0, commit},       32'd0);
        check("lw_exec_dREN",  {31'd0, dmemREN},      32'd0);
        tick();
        MemRead = 1'b0;   // flags are latched; decoder may change
        for (int i = 0; i < 2; i++) begin
            #1;
            check("lw_dREN",   {31'd0, dmemREN},      32'd1);
            check("lw_dWEN",   {31'd0, dmemWEN},      32'd0);
            check("lw_commit", {31'd0, commit},       32'd0);
            tick();
        end
        dhit = 1'b1;
        #1;
        check("lw_hit_dREN",   {31'd0, dmemREN},      32'd1);
        check("lw_hit_commit", {31'd0, commit},       32'd1);
        tick();
        dhit = 1'b0;
        #1;
        check("lw_drop_dREN",  {31'd0, dmemREN},      32'd0);
        check("lw_pc",         pc,                    32'hC);
        check("lw_no_commit",  {31'd0, commit},       32'd0);

        // ---------------- jumps and branches ----------------
        run_simple("j_to_40",  32'h0800_0010, 3'b010, 1'b0, 32'h0, 32'h0000_0040);
        run_simple("beq_taken",32'h1000_FFFE, 3'b001, 1'b1, 32'h0, 32'h0000_003C);
        run_simple("seq_3c",   32'h0000_0000, 3'b000, 1'b0, 32'h0, 32'h0000_0040);
        run_simple("beq_nt",   32'h1000_FFFE, 3'b001, 1'b0, 32'h0, 32'h0000_0044);
        run_simple("beq_back", 32'h1000_FFFE, 3'b001, 1'b1, 32'h0, 32'h0000_0040);
        run_simple("bne_taken",32'h1400_FFFE, 3'b100, 1'b0, 32'h0, 32'h0000_003C);
        run_simple("bne_nt",   32'h1400_FFFE, 3'b100, 1'b1, 32'h0, 32'h0000_0040);
        run_simple("jr_hi",    32'h0000_0008, 3'b011, 1'b0, 32'h1000_0003, 32'h1000_0000);
        run_simple("j_region", 32'h0800_0010, 3'b010, 1'b0, 32'h0, 32'h1000_0040);
        run_simple("jr_123",   32'h0000_0008, 3'b011, 1'b0, 32'h0000_0123, 32'h0000_0120);
        run_simple("sel_101",  32'h1000_FFFE, 3'b101, 1'b1, 32'h0, 32'h0000_0124);

        // ---------------- load+store together ----------------
        ihit     = 1'b1;
        imemload = 32'hAC43_0000;
        tick();
        ihit     = 1'b0;
        MemRead  = 1'b1;
        MemWrite = 1'b1;
        tick();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        dhit     = 1'b1;
        #1;
        check("both_dREN",     {31'd0, dmemREN},      32'd1);
        check("both_dWEN",     {31'd0, dmemWEN},      32'd1);
        check("both_commit",   {31'd0, commit},       32'd1);
        tick();
        dhit = 1'b0;
        #1;
        check("both_pc",       pc,                    32'h0000_0128);

        // ---------------- halt ----------------
        ihit     = 1'b1;
        imemload = 32'hFFFF_FFFF;
        tick();
        ihit    = 1'b0;
        halt_in = 1'b1;
        PC_src  = 3'b010;
        #1;
        check("halt_commit",   {31'd0, commit},       32'd0);
        tick();
        idle_inputs();
        ihit = 1'b1;
        dhit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("halt_flag",    {31'd0, halt},        32'd1);
            check("halt_pc",      pc,                   32'h0000_0128);
            check("halt_imemREN", {31'd0, imemREN},     32'd0);
            check("halt_valid",   {31'd0, instr_valid}, 32'd0);
            check("halt_commit2", {31'd0, commit},      32'd0);
            tick();
        end
        idle_inputs();

        // ---------------- reset mid-DATA with pending dhit ----------------
        RST = 1'b1;
        tick();
        RST = 1'b0;
        ihit     = 1'b1;
        imemload = 32'hAC43_0000;
        tick();
        ihit     = 1'b0;
        MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        #1;
        check("rd_dWEN",       {31'd0, dmemWEN},      32'd1);
        dhit = 1'b1;
        RST  = 1'b1;
        #1;
        check("rd_commit",     {31'd0, commit},       32'd0);
        tick();
        RST  = 1'b0;
        dhit = 1'b0;
        #1;
        check("rd_pc",         pc,                    32'h0);
        check("rd_halt",       {31'd0, halt},         32'd0);
        check("rd_dWEN_off",   {31'd0, dmemWEN},      32'd0);
        check("rd_imemREN",    {31'd0, imemREN},      32'd1);
        check("rd_valid",      {31'd0, instr_valid},  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
